// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, bus layouts and FSM encodings.
// The optional forwarding path in mem_stage is enabled by defining MEM_FWD_EN.
package mem_stage_pkg;

   localparam int EX_TO_MEM_BUS_WD = 109;
   localparam int MEM_TO_WB_BUS_WD = 108;
   localparam int MEM_TO_ID_BUS_WD = 39;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Field order matches the concatenation used by the EX stage (first member is the MSB).
   typedef struct packed {
      logic        sel_rf_w_en;
      logic        sel_rf_w_data;
      logic        sel_data_ram_wd;
      logic [3:0]  data_ram_b_en;
      logic        data_ram_we;
      logic [31:0] data_ram_w_data;
      logic [4:0]  rf_w_addr;
      logic [31:0] alu_result;
      logic [31:0] inst_pc;
   } ex_to_mem_t;

   typedef struct packed {
      logic        sel_rf_w_en;
      logic        sel_rf_w_data;
      logic        sel_data_ram_wd;
      logic [3:0]  data_ram_b_en;
      logic [31:0] data_ram_r_data;
      logic [4:0]  rf_w_addr;
      logic [31:0] alu_result;
      logic [31:0] inst_pc;
   } mem_to_wb_t;

   typedef struct packed {
      logic        fwd_w_en;
      logic        fwd_data_ready;
      logic [31:0] fwd_w_data;
      logic [4:0]  fwd_w_addr;
   } mem_to_id_t;

   // Loads and stores both need a data RAM transaction.
   function automatic logic is_mem_op(input ex_to_mem_t e);
      return e.sel_rf_w_data | e.data_ram_we;
   endfunction

endpackage

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, single-outstanding data SRAM FSM and load response buffer.
// Define MEM_FWD_EN to drive the MEM->ID forwarding bus; otherwise it is tied to zero.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                        clk,
   input  logic                        resetn,
   input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus,
   input  logic                        EX_to_MEM_valid,
   output logic                        MEM_allow_in,
   output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
   output logic                        MEM_to_WB_valid,
   input  logic                        WB_allow_in,
   output logic                        data_sram_req,
   output logic                        data_sram_wr,
   output logic [3:0]                  data_sram_wstrb,
   output logic [31:0]                 data_sram_addr,
   output logic [31:0]                 data_sram_wdata,
   input  logic                        data_sram_addr_ok,
   input  logic                        data_sram_data_ok,
   input  logic [31:0]                 data_sram_rdata,
   output logic [MEM_TO_ID_BUS_WD-1:0] MEM_to_ID_bus,
   output logic [1:0]                  dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid & allow_in are both high;
   // the sender holds its bus stable while valid is high and allow_in is low.
   ex_to_mem_t  ex_in;
   ex_to_mem_t  ex_mem_q, ex_mem_d;
   logic [1:0]  state_q, state_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] rsp_buf_q, rsp_buf_d;
   logic        ready_go;
   logic        capture;
   logic        is_load;
   logic        is_store;
   mem_to_wb_t  wb_bus;

   assign ex_in    = EX_to_MEM_bus;
   assign is_load  = ex_mem_q.sel_rf_w_data;
   assign is_store = ex_mem_q.data_ram_we;
   assign ready_go = (state_q == ST_DONE);

   assign MEM_allow_in    = ~mem_valid_q | (ready_go & WB_allow_in);
   assign MEM_to_WB_valid = mem_valid_q & ready_go;
   assign capture         = EX_to_MEM_valid & MEM_allow_in;

   always_comb begin
      ex_mem_d    = ex_mem_q;
      mem_valid_d = mem_valid_q;
      state_d     = state_q;
      rsp_buf_d   = rsp_buf_q;
      case (state_q)
         ST_REQ: begin
            if (data_sram_addr_ok) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (data_sram_data_ok) begin
               state_d = ST_DONE;
               if (is_load) rsp_buf_d = data_sram_rdata;
            end
         end
         ST_DONE: begin
            if (WB_allow_in) begin
               state_d     = ST_IDLE;
               mem_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
      // Capture is only possible from IDLE or a retiring DONE, so it never races the buffer update.
      if (capture) begin
         ex_mem_d    = ex_in;
         mem_valid_d = 1'b1;
         state_d     = is_mem_op(ex_in) ? ST_REQ : ST_DONE;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ex_mem_q    <= '0;
         mem_valid_q <= 1'b0;
         state_q     <= ST_IDLE;
         rsp_buf_q   <= '0;
      end else begin
         ex_mem_q    <= ex_mem_d;
         mem_valid_q <= mem_valid_d;
         state_q     <= state_d;
         rsp_buf_q   <= rsp_buf_d;
      end
   end

   assign data_sram_req   = (state_q == ST_REQ);
   assign data_sram_wr    = is_store;
   assign data_sram_wstrb = is_store ? ex_mem_q.data_ram_b_en : 4'b0000;
   assign data_sram_addr  = ex_mem_q.alu_result;
   assign data_sram_wdata = ex_mem_q.data_ram_w_data;

   always_comb begin
      wb_bus                 = '0;
      wb_bus.sel_rf_w_en     = ex_mem_q.sel_rf_w_en;
      wb_bus.sel_rf_w_data   = ex_mem_q.sel_rf_w_data;
      wb_bus.sel_data_ram_wd = ex_mem_q.sel_data_ram_wd;
      wb_bus.data_ram_b_en   = ex_mem_q.data_ram_b_en;
      wb_bus.data_ram_r_data = is_load ? rsp_buf_q : 32'b0;
      wb_bus.rf_w_addr       = ex_mem_q.rf_w_addr;
      wb_bus.alu_result      = ex_mem_q.alu_result;
      wb_bus.inst_pc         = ex_mem_q.inst_pc;
   end

   assign MEM_to_WB_bus = wb_bus;

`ifdef MEM_FWD_EN
   mem_to_id_t fwd_bus;

   // data_ready is qualified by valid so the bus reads all-zero out of reset.
   always_comb begin
      fwd_bus                = '0;
      fwd_bus.fwd_w_en       = mem_valid_q & ex_mem_q.sel_rf_w_en;
      fwd_bus.fwd_data_ready = mem_valid_q & (~is_load | (state_q == ST_DONE));
      fwd_bus.fwd_w_data     = is_load ? rsp_buf_q : ex_mem_q.alu_result;
      fwd_bus.fwd_w_addr     = ex_mem_q.rf_w_addr;
   end

   assign MEM_to_ID_bus = fwd_bus;
`else
   assign MEM_to_ID_bus = '0;
`endif

   assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: non-memory op, load, store, WB stall, reset mid-transaction.
// Forwarding-bus checks follow MEM_FWD_EN the same way the design does.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic         clk;
   logic         resetn;
   logic [108:0] EX_to_MEM_bus;
   logic         EX_to_MEM_valid;
   logic         MEM_allow_in;
   logic [107:0] MEM_to_WB_bus;
   logic         MEM_to_WB_valid;
   logic         WB_allow_in;
   logic         data_sram_req;
   logic         data_sram_wr;
   logic [3:0]   data_sram_wstrb;
   logic [31:0]  data_sram_addr;
   logic [31:0]  data_sram_wdata;
   logic         data_sram_addr_ok;
   logic         data_sram_data_ok;
   logic [31:0]  data_sram_rdata;
   logic [38:0]  MEM_to_ID_bus;
   logic [1:0]   dbg_state;

   int total;
   int bad;

   mem_stage dut (
      .clk               (clk),
      .resetn            (resetn),
      .EX_to_MEM_bus     (EX_to_MEM_bus),
      .EX_to_MEM_valid   (EX_to_MEM_valid),
      .MEM_allow_in      (MEM_allow_in),
      .MEM_to_WB_bus     (MEM_to_WB_bus),
      .MEM_to_WB_valid   (MEM_to_WB_valid),
      .WB_allow_in       (WB_allow_in),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .MEM_to_ID_bus     (MEM_to_ID_bus),
      .dbg_state         (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [108:0] mk_ex(input logic en, input logic ld, input logic wd,
                                          input logic [3:0] ben, input logic we,
                                          input logic [31:0] wdata, input logic [4:0] waddr,
                                          input logic [31:0] alu, input logic [31:0] pc);
      return {en, ld, wd, ben, we, wdata, waddr, alu, pc};
   endfunction

   function automatic logic [107:0] mk_wb(input logic en, input logic ld, input logic wd,
                                          input logic [3:0] ben, input logic [31:0] rdata,
                                          input logic [4:0] waddr, input logic [31:0] alu,
                                          input logic [31:0] pc);
      return {en, ld, wd, ben, rdata, waddr, alu, pc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick();
      tick();
      total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b exp=0", MEM_to_WB_valid); end
      total++; if (data_sram_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", data_sram_req); end
      total++; if (MEM_allow_in !== 1'b1) begin bad++; $display("FAIL rst_allow_in got=%b exp=1", MEM_allow_in); end
      total++; if (MEM_to_ID_bus !== 39'd0) begin bad++; $display("FAIL rst_id_bus got=%h exp=0", MEM_to_ID_bus); end
      total++; if (MEM_to_WB_bus !== 108'd0) begin bad++; $display("FAIL rst_wb_bus got=%h exp=0", MEM_to_WB_bus); end
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_nonmem();
      logic [107:0] exp_wb;
      exp_wb = mk_wb(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 5'd3, 32'h0000_1234, 32'h1C00_0100);
      WB_allow_in     = 1'b1;
      EX_to_MEM_valid = 1'b1;
      EX_to_MEM_bus   = mk_ex(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0, 5'd3, 32'h0000_1234, 32'h1C00_0100);
      settle();
      total++; if (MEM_allow_in !== 1'b1) begin bad++; $display("FAIL nm_allow_pre got=%b exp=1", MEM_allow_in); end
      tick();
      EX_to_MEM_valid = 1'b0;
      settle();
      total++; if (MEM_to_WB_valid !== 1'b1) begin bad++; $display("FAIL nm_wb_valid got=%b exp=1", MEM_to_WB_valid); end
      total++; if (MEM_to_WB_bus !== exp_wb) begin bad++; $display("FAIL nm_wb_bus got=%h exp=%h", MEM_to_WB_bus, exp_wb); end
      total++; if (data_sram_req !== 1'b0) begin bad++; $display("FAIL nm_req got=%b exp=0", data_sram_req); end
`ifdef MEM_FWD_EN
      total++; if (MEM_to_ID_bus !== {1'b1, 1'b1, 32'h0000_1234, 5'd3}) begin bad++; $display("FAIL nm_id_bus got=%h", MEM_to_ID_bus); end
`endif
      tick();
      total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL nm_wb_drop got=%b exp=0", MEM_to_WB_valid); end
      total++; if (data_sram_req !== 1'b0) begin bad++; $display("FAIL nm_req_after got=%b exp=0", data_sram_req); end
   endtask

   task automatic test_load();
      logic [107:0] exp_wb;
      exp_wb = mk_wb(1'b1, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF, 5'd5, 32'h1C00_0010, 32'h1C00_0200);
      WB_allow_in     = 1'b1;
      EX_to_MEM_valid = 1'b1;
      EX_to_MEM_bus   = mk_ex(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 32'h5555_5555, 5'd5, 32'h1C00_0010, 32'h1C00_0200);
      tick();
      // req cycle 1: stray data_ok must be ignored outside WAIT
      EX_to_MEM_valid   = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1111_1111;
      settle();
      total++; if (data_sram_req !== 1'b1) begin bad++; $display("FAIL ld_req_c1 got=%b exp=1", data_sram_req); end
      total++; if ({data_sram_addr, data_sram_wr, data_sram_wstrb} !== {32'h1C00_0010, 1'b0, 4'b0000}) begin bad++; $display("FAIL ld_cmd_c1 got=%h/%b/%b exp=1c000010/0/0000", data_sram_addr, data_sram_wr, data_sram_wstrb); end
      total++; if (MEM_allow_in !== 1'b0) begin bad++; $display("FAIL ld_allow_c1 got=%b exp=0", MEM_allow_in); end
`ifdef MEM_FWD_EN
      total++; if ({MEM_to_ID_bus[38:37], MEM_to_ID_bus[4:0]} !== {2'b10, 5'd5}) begin bad++; $display("FAIL ld_fwd_pending got=%h", MEM_to_ID_bus); end
`else
      total++; if (MEM_to_ID_bus !== 39'd0) begin bad++; $display("FAIL ld_id_zero got=%h exp=0", MEM_to_ID_bus); end
`endif
      tick();
      data_sram_data_ok = 1'b0;
      settle();
      total++; if ({data_sram_req, data_sram_addr, data_sram_wr, data_sram_wstrb} !== {1'b1, 32'h1C00_0010, 1'b0, 4'b0000}) begin bad++; $display("FAIL ld_cmd_c2 got=%b/%h/%b/%b", data_sram_req, data_sram_addr, data_sram_wr, data_sram_wstrb); end
      tick();
      data_sram_addr_ok = 1'b1;
      settle();
      total++; if ({data_sram_req, data_sram_addr, data_sram_wr, data_sram_wstrb} !== {1'b1, 32'h1C00_0010, 1'b0, 4'b0000}) begin bad++; $display("FAIL ld_cmd_c3 got=%b/%h/%b/%b", data_sram_req, data_sram_addr, data_sram_wr, data_sram_wstrb); end
      tick();
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hDEAD_BEEF;
      settle();
      total++; if (data_sram_req !== 1'b0) begin bad++; $display("FAIL ld_req_wait got=%b exp=0", data_sram_req); end
      total++; if (dbg_state !== ST_WAIT) begin bad++; $display("FAIL ld_state_wait got=%0d exp=%0d", dbg_state, ST_WAIT); end
      total++; if ({MEM_allow_in, MEM_to_WB_valid} !== 2'b00) begin bad++; $display("FAIL ld_hs_wait got=%b exp=00", {MEM_allow_in, MEM_to_WB_valid}); end
      tick();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      settle();
      total++; if (MEM_to_WB_valid !== 1'b1) begin bad++; $display("FAIL ld_wb_valid got=%b exp=1", MEM_to_WB_valid); end
      total++; if (MEM_to_WB_bus !== exp_wb) begin bad++; $display("FAIL ld_wb_bus got=%h exp=%h", MEM_to_WB_bus, exp_wb); end
`ifdef MEM_FWD_EN
      total++; if (MEM_to_ID_bus !== {1'b1, 1'b1, 32'hDEAD_BEEF, 5'd5}) begin bad++; $display("FAIL ld_fwd_done got=%h", MEM_to_ID_bus); end
`endif
      tick();
      total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL ld_wb_drop got=%b exp=0", MEM_to_WB_valid); end
   endtask

   task automatic test_store();
      logic [107:0] exp_wb;
      exp_wb = mk_wb(1'b0, 1'b0, 1'b0, 4'b0100, 32'h0, 5'd0, 32'h1C00_0020, 32'h1C00_0300);
      WB_allow_in     = 1'b1;
      EX_to_MEM_valid = 1'b1;
      EX_to_MEM_bus   = mk_ex(1'b0, 1'b0, 1'b0, 4'b0100, 1'b1, 32'h00AB_0000, 5'd0, 32'h1C00_0020, 32'h1C00_0300);
      tick();
      EX_to_MEM_valid   = 1'b0;
      data_sram_addr_ok = 1'b1;
      settle();
      total++; if ({data_sram_req, data_sram_wr, data_sram_wstrb} !== {1'b1, 1'b1, 4'b0100}) begin bad++; $display("FAIL st_cmd got=%b/%b/%b exp=1/1/0100", data_sram_req, data_sram_wr, data_sram_wstrb); end
      total++; if ({data_sram_addr, data_sram_wdata} !== {32'h1C00_0020, 32'h00AB_0000}) begin bad++; $display("FAIL st_addr_data got=%h/%h exp=1c000020/00ab0000", data_sram_addr, data_sram_wdata); end
      tick();
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'hCAFE_F00D;
      settle();
      total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL st_wb_early got=%b exp=0", MEM_to_WB_valid); end
      tick();
      data_sram_data_ok = 1'b0;
      settle();
      total++; if (MEM_to_WB_valid !== 1'b1) begin bad++; $display("FAIL st_wb_valid got=%b exp=1", MEM_to_WB_valid); end
      total++; if (MEM_to_WB_bus !== exp_wb) begin bad++; $display("FAIL st_wb_bus got=%h exp=%h", MEM_to_WB_bus, exp_wb); end
      tick();
   endtask

   task automatic test_wb_stall();
      logic [107:0] exp_ld;
      logic [107:0] exp_nm;
      exp_ld = mk_wb(1'b1, 1'b1, 1'b1, 4'b1111, 32'h1234_5678, 5'd9, 32'h1C00_0040, 32'h1C00_0400);
      exp_nm = mk_wb(1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, 5'd7, 32'h0000_0055, 32'h1C00_0404);
      WB_allow_in     = 1'b0;
      EX_to_MEM_valid = 1'b1;
      EX_to_MEM_bus   = mk_ex(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 32'h0, 5'd9, 32'h1C00_0040, 32'h1C00_0400);
      tick();
      EX_to_MEM_valid   = 1'b0;
      data_sram_addr_ok = 1'b1;
      tick();
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h1234_5678;
      tick();
      // WB stalls for 3 cycles while a non-memory op waits upstream; late data_ok must not disturb the buffer
      EX_to_MEM_valid = 1'b1;
      EX_to_MEM_bus   = mk_ex(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0, 5'd7, 32'h0000_0055, 32'h1C00_0404);
      data_sram_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 3; i++) begin
         settle();
         total++; if ({MEM_to_WB_valid, MEM_allow_in, data_sram_req} !== 3'b100) begin bad++; $display("FAIL stall_hs_%0d got=%b exp=100", i, {MEM_to_WB_valid, MEM_allow_in, data_sram_req}); end
         total++; if (MEM_to_WB_bus !== exp_ld) begin bad++; $display("FAIL stall_bus_%0d got=%h exp=%h", i, MEM_to_WB_bus, exp_ld); end
         tick();
      end
      data_sram_data_ok = 1'b0;
      WB_allow_in       = 1'b1;
      settle();
      total++; if ({MEM_to_WB_valid, MEM_allow_in} !== 2'b11) begin bad++; $display("FAIL stall_release got=%b exp=11", {MEM_to_WB_valid, MEM_allow_in}); end
      tick();
      EX_to_MEM_valid = 1'b0;
      settle();
      total++; if (MEM_to_WB_valid !== 1'b1) begin bad++; $display("FAIL b2b_wb_valid got=%b exp=1", MEM_to_WB_valid); end
      total++; if (MEM_to_WB_bus !== exp_nm) begin bad++; $display("FAIL b2b_wb_bus got=%h exp=%h", MEM_to_WB_bus, exp_nm); end
      tick();
      total++; if (MEM_to_WB_valid !== 1'b0) begin bad++; $display("FAIL b2b_drop got=%b exp=0", MEM_to_WB_valid); end
   endtask

   task automatic test_reset_mid();
      logic [107:0] exp_wb;
      exp_wb = mk_wb(1'b1, 1'b1, 1'b1, 4'b1111, 32'h0BAD_F00D, 5'd2, 32'h1C00_0080, 32'h1C00_0504);
      WB_allow_in     = 1'b1;
      EX_to_MEM_valid = 1'b1;
      EX_to_MEM_bus   = mk_ex(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 32'h0, 5'd4, 32'h1C00_0060, 32'h1C00_0500);
      tick();
      EX_to_MEM_valid   = 1'b0;
      data_sram_addr_ok = 1'b1;
      tick();
      data_sram_addr_ok = 1'b0;
      resetn            = 1'b0;
      settle();
      total++; if ({MEM_to_WB_valid, data_sram_req, MEM_allow_in} !== 3'b001) begin bad++; $display("FAIL mid_rst_hs got=%b exp=001", {MEM_to_WB_valid, data_sram_req, MEM_allow_in}); end
      total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL mid_rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
      total++; if ({MEM_to_ID_bus, MEM_to_WB_bus} !== 147'd0) begin bad++; $display("FAIL mid_rst_buses got=%h/%h exp=0", MEM_to_ID_bus, MEM_to_WB_bus); end
      tick();
      resetn = 1'b1;
      tick();
      EX_to_MEM_valid = 1'b1;
      EX_to_MEM_bus   = mk_ex(1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, 32'h0, 5'd2, 32'h1C00_0080, 32'h1C00_0504);
      tick();
      EX_to_MEM_valid   = 1'b0;
      data_sram_addr_ok = 1'b1;
      settle();
      total++; if ({data_sram_req, data_sram_addr} !== {1'b1, 32'h1C00_0080}) begin bad++; $display("FAIL mid_fresh_req got=%b/%h exp=1/1c000080", data_sram_req, data_sram_addr); end
      tick();
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h0BAD_F00D;
      tick();
      data_sram_data_ok = 1'b0;
      settle();
      total++; if ({MEM_to_WB_valid, MEM_to_WB_bus} !== {1'b1, exp_wb}) begin bad++; $display("FAIL mid_fresh_wb got=%b/%h exp=1/%h", MEM_to_WB_valid, MEM_to_WB_bus, exp_wb); end
      tick();
   endtask

   initial begin
      total             = 0;
      bad               = 0;
      resetn            = 1'b0;
      EX_to_MEM_bus     = '0;
      EX_to_MEM_valid   = 1'b0;
      WB_allow_in       = 1'b1;
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      test_reset();
      test_nonmem();
      test_load();
      test_store();
      test_wb_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; resetn  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: EX_to_MEM_bus  in  `EX_TO_MEM_BUS_WD (109)  {sel_rf_w_en, sel_rf_w_data, sel_data_ram_wd, data_ram_b_en[3:0], data_ram_we, data_ram_w_data[31:0], RegFile_w_addr[4:0], alu_result[31:0], inst_PC[31:0]}; EX_to_MEM_valid  in  1; MEM_allow_in  out  1.
REQ-003 SHALL have ports: MEM_to_WB_bus  out  `MEM_TO_WB_BUS_WD (108)  {sel_rf_w_en, sel_rf_w_data, sel_data_ram_wd, data_ram_b_en, data_ram_r_data[31:0], RegFile_w_addr, alu_result, inst_PC}; MEM_to_WB_valid  out  1; WB_allow_in  in  1.
REQ-004 SHALL have ports: data_sram_req  out  1; data_sram_wr  out  1; data_sram_wstrb  out  4; data_sram_addr  out  32; data_sram_wdata  out  32; data_sram_addr_ok  in  1; data_sram_data_ok  in  1; data_sram_rdata  in  32.
REQ-005 SHALL have port MEM_to_ID_bus  out  `MEM_TO_ID_BUS_WD (39)  {fwd_w_en, fwd_data_ready, fwd_w_data[31:0], fwd_w_addr[4:0]}.

Function
REQ-006 SHALL classify a captured instruction as a load (sel_rf_w_data=1), a store (data_ram_we=1), or a non-memory op (neither set).
REQ-007 SHALL capture EX_to_MEM_bus into the EX/MEM register on a rising edge where EX_to_MEM_valid & MEM_allow_in; the register otherwise holds.
REQ-008 SHALL drive MEM_allow_in = ~MEM_valid | (MEM_ready_go & WB_allow_in) and MEM_to_WB_valid = MEM_valid & MEM_ready_go.
REQ-009 SHALL use FSM states IDLE, REQ, WAIT, DONE. On capture of a load/store: go to REQ; on capture of a non-memory op: go to DONE.
REQ-010 SHALL assert data_sram_req only in REQ, holding addr=alu_result, wr=data_ram_we, wstrb=(store ? data_ram_b_en : 4'b0000), wdata=data_ram_w_data stable until addr_ok; REQ->WAIT on addr_ok.
REQ-011 SHALL sample data_ram data_ok only in WAIT; WAIT->DONE on data_ok, latching data_sram_rdata into a 32-bit response buffer (stores latch nothing).
REQ-012 SHALL assert MEM_ready_go only in DONE; DONE exits on WB_allow_in, to REQ/DONE if a new instruction is captured the same edge, else IDLE.
REQ-013 SHALL drive MEM_to_WB_bus data_ram_r_data from the response buffer for loads and 32'b0 otherwise; the buffer holds while WB stalls. All other fields pass through unchanged.
REQ-014 SHALL provide non-memory latency of 1 cycle from capture to MEM_to_WB_valid; load latency of 1 + (cycles to addr_ok) + (cycles to data_ok) + 1.
REQ-015 SHALL issue at most one outstanding data request; no new capture occurs while in REQ or WAIT.
REQ-016 SHALL ignore data_sram_addr_ok outside REQ and data_sram_data_ok outside WAIT.

Reset
REQ-017 SHALL, on resetn low (asynchronously): MEM_valid=0, FSM=IDLE, EX/MEM register=0, response buffer=0; hence MEM_to_WB_valid=0, data_sram_req=0, MEM_allow_in=1, MEM_to_ID_bus=0.
REQ-018 SHALL abandon any in-flight request on reset; the data RAM shares resetn, so no response survives reset.

Configuration
REQ-019 SHALL, with MEM_FWD_EN defined, drive MEM_to_ID_bus: fwd_w_en=MEM_valid & sel_rf_w_en, fwd_data_ready=(non-load | state==DONE), fwd_w_data=(load ? response buffer : alu_result), fwd_w_addr=RegFile_w_addr.
REQ-020 SHALL, without MEM_FWD_EN, drive MEM_to_ID_bus constant 0 and instantiate no forwarding logic.

Structure
REQ-021 SHALL take bus widths (`EX_TO_MEM_BUS_WD, `MEM_TO_WB_BUS_WD, `MEM_TO_ID_BUS_WD) and FSM state encodings from the shared myCPU.h header.
REQ-022 SHALL be one module with no sub-modules; the FSM and response buffer are inline.

Verification
REQ-023 Non-memory op, alu_result=32'h0000_1234, WB_allow_in=1 -> MEM_to_WB_valid high 1 cycle after capture, alu_result=32'h1234, r_data=0, data_sram_req never asserted.
REQ-024 Load, addr 32'h1C00_0010, addr_ok after 2 cycles, data_ok 1 cycle later with rdata 32'hDEAD_BEEF -> req held 3 cycles with stable addr/wr=0/wstrb=0; MEM_to_WB r_data=32'hDEADBEEF; MEM_allow_in=0 throughout.
REQ-025 Store, b_en=4'b0100, wdata=32'h00AB_0000 -> req with wr=1, wstrb=4'b0100; completes on data_ok; WB bus r_data=0.
REQ-026 Load completes while WB_allow_in=0 for 3 cycles -> buffer and MEM_to_WB_valid held; no second request; pipeline advances on the cycle WB_allow_in rises.
REQ-027 resetn pulled low while in WAIT -> outputs reach reset values immediately; the next capture after release issues a fresh request.
REQ-028 With MEM_FWD_EN: pending load to r5 -> MEM_to_ID_bus fwd_w_en=1, fwd_data_ready=0, fwd_w_addr=5 until DONE, then fwd_data_ready=1 with the loaded data.
